// File: rtl/branch_pc_if.sv
// Fetch-redirect bundle between the EX-stage branch resolution, the hazard
// unit, instruction memory and the PC unit.
interface branch_pc_if #(
    parameter int unsigned N = 32
);
    logic         stall;
    logic         imem_ready;
    logic         br_taken;
    logic [N-1:0] br_pc;
    logic [N-1:0] offset_sh;
    logic         jalr_taken;
    logic [N-1:0] jalr_target;
    logic [N-1:0] pc;
    logic         pc_valid;
    logic         flush;
    logic         misalign;
    logic         halted;

    modport master (
        output stall, imem_ready, br_taken, br_pc, offset_sh, jalr_taken, jalr_target,
        input  pc, pc_valid, flush, misalign, halted
    );

    modport slave (
        input  stall, imem_ready, br_taken, br_pc, offset_sh, jalr_taken, jalr_target,
        output pc, pc_valid, flush, misalign, halted
    );
endinterface

// File: rtl/branch_pc_unit.sv
// Program counter and next-PC selection: sequential fetch, branch/JAL/JALR
// redirect, one-entry redirect buffer while imem stalls, misaligned-target trap.
module branch_pc_unit #(
    parameter int unsigned    N        = 32,
    parameter logic [N-1:0]   RESET_PC = '0
) (
    input  logic              clk,
    input  logic              rst_n,
    branch_pc_if.slave        bus
);
    typedef enum logic [1:0] {
        RUN  = 2'd0,
        HOLD = 2'd1,
        TRAP = 2'd2
    } state_t;

    state_t       state, state_n;
    logic [N-1:0] pc_q, pc_n;
    logic [N-1:0] pend_q, pend_n;
    logic         valid_q, valid_n;
    logic         flush_q, flush_n;
    logic         mis_q, mis_n;
    logic         halted_q, halted_n;

    logic         redir;
    logic [N-1:0] target;

    assign redir  = bus.br_taken | bus.jalr_taken;
    assign target = bus.jalr_taken ? {bus.jalr_target[N-1:1], 1'b0}
                                   : bus.br_pc + bus.offset_sh;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= RUN;
            pc_q     <= RESET_PC;
            pend_q   <= '0;
            valid_q  <= 1'b0;
            flush_q  <= 1'b0;
            mis_q    <= 1'b0;
            halted_q <= 1'b0;
        end else begin
            state    <= state_n;
            pc_q     <= pc_n;
            pend_q   <= pend_n;
            valid_q  <= valid_n;
            flush_q  <= flush_n;
            mis_q    <= mis_n;
            halted_q <= halted_n;
        end
    end

    always_comb begin
        state_n  = state;
        pc_n     = pc_q;
        pend_n   = pend_q;
        valid_n  = valid_q;
        flush_n  = 1'b0;
        mis_n    = 1'b0;
        halted_n = halted_q;

        case (state)
            RUN, HOLD: begin
                // Redirect is handled identically in RUN and HOLD; the newest
                // target always replaces any buffered one.
                if (redir) begin
                    flush_n = 1'b1;
                    if (target[1]) begin
                        mis_n    = 1'b1;
                        valid_n  = 1'b0;
                        halted_n = 1'b1;
                        state_n  = TRAP;
                    end else if (bus.imem_ready) begin
                        pc_n    = target;
                        valid_n = 1'b1;
                        state_n = RUN;
                    end else begin
                        pend_n  = target;
                        valid_n = 1'b0;
                        state_n = HOLD;
                    end
                end else if (state == HOLD) begin
                    if (bus.imem_ready) begin
                        pc_n    = pend_q;
                        valid_n = 1'b1;
                        state_n = RUN;
                    end
                end else begin
                    // Only an already-live request advances; the first cycle
                    // after reset presents RESET_PC.
                    valid_n = 1'b1;
                    if (!bus.stall && bus.imem_ready && valid_q)
                        pc_n = pc_q + N'(4);
                end
            end
            default: begin
                valid_n  = 1'b0;
                halted_n = 1'b1;
                state_n  = TRAP;
            end
        endcase
    end

    assign bus.pc       = pc_q;
    assign bus.pc_valid = valid_q;
    assign bus.flush    = flush_q;
    assign bus.misalign = mis_q;
    assign bus.halted   = halted_q;
endmodule

// File: tb/tb_branch_pc_unit.sv
// Self-checking bench for branch_pc_unit: directed scenarios with literal
// expectations plus randomized traffic against a behavioural model.
module tb_branch_pc_unit;
    localparam int unsigned N = 32;

    logic clk = 1'b0;
    logic rst_n = 1'b1;
    always #5 clk = ~clk;

    branch_pc_if #(.N(N)) bus ();

    branch_pc_unit #(.N(N), .RESET_PC(32'h0)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    int n_cmp = 0;
    int n_bad = 0;

    // behavioural model
    logic [31:0] m_pc, m_pend;
    logic        m_valid, m_flush, m_mis, m_halted;
    bit          m_hold, m_trap;

    task automatic model_reset();
        m_pc = 32'h0; m_pend = 32'h0; m_valid = 0; m_flush = 0;
        m_mis = 0; m_halted = 0; m_hold = 0; m_trap = 0;
    endtask

    task automatic model_edge();
        logic [31:0] tgt;
        if (!rst_n) begin
            model_reset();
            return;
        end
        m_flush = 0;
        m_mis   = 0;
        if (m_trap) return;
        if (bus.jalr_taken) tgt = bus.jalr_target & 32'hFFFF_FFFE;
        else                tgt = bus.br_pc + bus.offset_sh;
        if (bus.br_taken || bus.jalr_taken) begin
            m_flush = 1;
            if (tgt % 4 != 0) begin
                m_mis = 1; m_trap = 1; m_halted = 1; m_valid = 0;
            end else if (bus.imem_ready) begin
                m_pc = tgt; m_valid = 1; m_hold = 0;
            end else begin
                m_pend = tgt; m_valid = 0; m_hold = 1;
            end
        end else if (m_hold) begin
            if (bus.imem_ready) begin
                m_pc = m_pend; m_valid = 1; m_hold = 0;
            end
        end else begin
            if (!bus.stall && bus.imem_ready && m_valid) m_pc = m_pc + 4;
            m_valid = 1;
        end
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic compare_all();
        chk("pc",       bus.pc,              m_pc);
        chk("pc_valid", 32'(bus.pc_valid),   32'(m_valid));
        chk("flush",    32'(bus.flush),      32'(m_flush));
        chk("misalign", 32'(bus.misalign),   32'(m_mis));
        chk("halted",   32'(bus.halted),     32'(m_halted));
    endtask

    task automatic step();
        @(posedge clk);
        model_edge();
        #1;
        compare_all();
    endtask

    task automatic idle_inputs();
        bus.stall = 0; bus.imem_ready = 1; bus.br_taken = 0; bus.jalr_taken = 0;
        bus.br_pc = '0; bus.offset_sh = '0; bus.jalr_target = '0;
    endtask

    task automatic async_reset();
        rst_n = 0;
        #1;
        model_reset();
        compare_all();
    endtask

    initial begin
        int trap_cycles;
        idle_inputs();
        #2;
        async_reset();
        chk("reset_pc", bus.pc, 32'h0);
        chk("reset_valid", 32'(bus.pc_valid), 32'h0);
        step();
        rst_n = 1;

        // 1: sequential fetch after reset
        for (int i = 0; i < 4; i++) begin
            step();
            chk("seq_pc", bus.pc, 32'(4 * i));
            chk("seq_valid", 32'(bus.pc_valid), 32'h1);
        end

        // 2: taken branch
        bus.br_taken = 1; bus.br_pc = 32'h100; bus.offset_sh = 32'h20;
        step();
        chk("br_pc", bus.pc, 32'h120);
        chk("br_flush", 32'(bus.flush), 32'h1);
        bus.br_taken = 0;
        step();
        chk("br_flush_end", 32'(bus.flush), 32'h0);
        chk("br_next", bus.pc, 32'h124);

        // 3: redirect overrides stall, negative offset
        bus.stall = 1; bus.br_taken = 1; bus.br_pc = 32'h40; bus.offset_sh = 32'hFFFF_FFF0;
        step();
        chk("stall_redir_pc", bus.pc, 32'h30);
        chk("stall_redir_flush", 32'(bus.flush), 32'h1);
        bus.br_taken = 0;
        step();
        chk("stall_hold_pc", bus.pc, 32'h30);
        bus.stall = 0;

        // 4: redirect while imem busy -> buffered
        bus.br_taken = 1; bus.br_pc = 32'h200; bus.offset_sh = 32'h0; bus.imem_ready = 0;
        step();
        chk("hold_valid", 32'(bus.pc_valid), 32'h0);
        chk("hold_flush", 32'(bus.flush), 32'h1);
        bus.br_taken = 0;
        step();
        step();
        chk("hold_valid2", 32'(bus.pc_valid), 32'h0);
        bus.imem_ready = 1;
        step();
        chk("hold_release_pc", bus.pc, 32'h200);
        chk("hold_release_valid", 32'(bus.pc_valid), 32'h1);

        // wrap of target and of pc+4
        bus.br_taken = 1; bus.br_pc = 32'hFFFF_FFFC; bus.offset_sh = 32'h8;
        step();
        chk("wrap_target", bus.pc, 32'h4);
        bus.br_pc = 32'hFFFF_FFF8; bus.offset_sh = 32'h4;
        step();
        bus.br_taken = 0;
        step();
        chk("wrap_inc", bus.pc, 32'h0);
        step();

        // 5: misaligned JALR target traps
        bus.jalr_taken = 1; bus.jalr_target = 32'h103;
        step();
        chk("mis_pulse", 32'(bus.misalign), 32'h1);
        chk("mis_halted", 32'(bus.halted), 32'h1);
        bus.jalr_taken = 0; bus.br_taken = 1; bus.br_pc = 32'h500;
        step();
        chk("mis_pulse_end", 32'(bus.misalign), 32'h0);
        chk("trap_flush", 32'(bus.flush), 32'h0);
        chk("trap_pc", bus.pc, 32'h4);
        chk("trap_halted", 32'(bus.halted), 32'h1);
        bus.br_taken = 0;
        async_reset();
        chk("trap_reset_halted", 32'(bus.halted), 32'h0);
        step();
        rst_n = 1;
        step();

        // 6: JALR wins over branch; reset mid-HOLD drops pend
        bus.br_taken = 1; bus.br_pc = 32'h100; bus.offset_sh = 32'h4;
        bus.jalr_taken = 1; bus.jalr_target = 32'h80;
        step();
        chk("jalr_wins", bus.pc, 32'h80);
        bus.jalr_taken = 0; bus.br_pc = 32'h300; bus.offset_sh = 32'h0; bus.imem_ready = 0;
        step();
        bus.br_taken = 0;
        async_reset();
        chk("hold_reset_pc", bus.pc, 32'h0);
        step();
        rst_n = 1; bus.imem_ready = 1;
        step();
        chk("reset_exit_flush", 32'(bus.flush), 32'h0);
        chk("reset_exit_pc", bus.pc, 32'h0);
        step();
        chk("reset_exit_inc", bus.pc, 32'h4);

        // randomized traffic
        trap_cycles = 0;
        for (int c = 0; c < 3000; c++) begin
            int r;
            if ((m_trap && trap_cycles > 3) || $urandom_range(0, 299) == 0) begin
                trap_cycles = 0;
                async_reset();
                step();
                rst_n = 1;
            end
            r = int'($urandom_range(0, 9));
            bus.stall      = ($urandom_range(0, 3) == 0);
            bus.imem_ready = ($urandom_range(0, 2) != 0);
            bus.br_taken   = (r == 0 || r == 2);
            bus.jalr_taken = (r == 1 || r == 2);
            bus.br_pc      = $urandom & 32'hFFFF_FFFC;
            bus.offset_sh  = ($urandom_range(0, 15) == 0) ? ($urandom & 32'hFFFF_FFFE)
                                                          : ($urandom & 32'hFFFF_FFFC);
            bus.jalr_target = ($urandom_range(0, 15) == 0) ? $urandom
                                                           : ($urandom & 32'hFFFF_FFFD);
            step();
            if (m_trap) trap_cycles++;
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
